// File: rtl/seq_restoring_divider_if.sv
// Start/busy/done handshake and operand/result bus for seq_restoring_divider.
// DIV_BY_ZERO_FLAG_EN adds the div_by_zero result flag.
interface seq_restoring_divider_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic             div_by_zero;
`endif

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
`ifdef DIV_BY_ZERO_FLAG_EN
    , input div_by_zero
`endif
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
`ifdef DIV_BY_ZERO_FLAG_EN
    , output div_by_zero
`endif
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock (IDLE -> CALC -> DONE).
// Optional macro DIV_BY_ZERO_FLAG_EN: zero divisor short-circuits to DONE and raises div_by_zero.
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 8
) (
  input logic clk,
  input logic rst,
  seq_restoring_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_sh;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  logic [WIDTH-1:0] rs;
  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] r_nxt;
  logic [WIDTH-1:0] q_nxt;

  // Trial subtraction; the borrow bit decides restore vs. keep and is the inverted quotient bit.
  always_comb begin
    rs    = {r[WIDTH-2:0], q_sh[WIDTH-1]};
    t     = {1'b0, rs} - {1'b0, d};
    r_nxt = t[WIDTH] ? rs : t[WIDTH-1:0];
    q_nxt = {q_sh[WIDTH-2:0], ~t[WIDTH]};
  end

`ifdef DIV_BY_ZERO_FLAG_EN
  logic dbz;
  assign bus.div_by_zero = dbz;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      q_sh  <= '0;
      d     <= '0;
      r     <= '0;
      quo   <= '0;
      rem   <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
`ifdef DIV_BY_ZERO_FLAG_EN
            if (bus.divisor == '0) begin
              state <= S_DONE;
              quo   <= '1;
              rem   <= bus.dividend;
              dbz   <= 1'b1;
            end else begin
              state <= S_CALC;
              q_sh  <= bus.dividend;
              d     <= bus.divisor;
              r     <= '0;
              cnt   <= CW'(WIDTH);
            end
`else
            state <= S_CALC;
            q_sh  <= bus.dividend;
            d     <= bus.divisor;
            r     <= '0;
            cnt   <= CW'(WIDTH);
`endif
          end
        end
        S_CALC: begin
          q_sh <= q_nxt;
          r    <= r_nxt;
          cnt  <= cnt - 1'b1;
          // Last iteration writes results straight from the datapath so DONE already shows them.
          if (cnt == CW'(1)) begin
            state <= S_DONE;
            quo   <= q_nxt;
            rem   <= r_nxt;
`ifdef DIV_BY_ZERO_FLAG_EN
            dbz   <= 1'b0;
`endif
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state == S_CALC);
  assign bus.done      = (state == S_DONE);
  assign bus.quotient  = quo;
  assign bus.remainder = rem;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=8), directed plus randomized operations.
// Honours DIV_BY_ZERO_FLAG_EN for divide-by-zero latency and flag expectations.
module tb_seq_restoring_divider;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();
  seq_restoring_divider #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic, divide-by-zero gives all ones / dividend.
  function automatic void model(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic bit short_path(input int b);
`ifdef DIV_BY_ZERO_FLAG_EN
    return (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  // Called at #1 after an edge with the DUT idle; returns the same way.
  task automatic run_op(input string tag, input int a, input int b);
    int q, r, lat, bcnt;
    model(a, b, q, r);
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    step();
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    lat = 0;
    bcnt = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcnt++;
      step();
      lat++;
    end
    check({tag, "_done"}, 32'(bus.done), 1);
    check({tag, "_lat"}, lat, short_path(b) ? 0 : W);
    check({tag, "_busycyc"}, bcnt, short_path(b) ? 0 : W);
    check({tag, "_q"}, bus.quotient, q);
    check({tag, "_r"}, bus.remainder, r);
`ifdef DIV_BY_ZERO_FLAG_EN
    check({tag, "_dbz"}, 32'(bus.div_by_zero), (b == 0) ? 1 : 0);
`endif
    step();
    check({tag, "_pulse"}, 32'(bus.done), 0);
  endtask

  initial begin
    int q, r, a, b;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    step();
    step();
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_q", bus.quotient, 0);
    check("rst_r", bus.remainder, 0);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("rst_dbz", 32'(bus.div_by_zero), 0);
`endif
    rst = 1'b0;
    step();

    run_op("basic_100_7", 100, 7);
    run_op("e255_1", 255, 1);
    run_op("e5_9", 5, 9);
    run_op("e0_3", 0, 3);
    run_op("e255_255", 255, 255);
    run_op("dz37_0", 37, 0);
    run_op("after_dz_10_3", 10, 3);

    // Result hold: inputs change without start.
    run_op("hold_100_7", 100, 7);
    for (int i = 0; i < 5; i++) begin
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      step();
    end
    check("hold_q", bus.quotient, 14);
    check("hold_r", bus.remainder, 2);
    check("hold_done", 32'(bus.done), 0);

    // start held high with new operands during CALC and DONE.
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    step();
    for (int i = 0; i < int'(W); i++) begin
      check("bb_busy", 32'(bus.busy), 1);
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      step();
    end
    check("bb_done1", 32'(bus.done), 1);
    check("bb_q1", bus.quotient, 14);
    check("bb_r1", bus.remainder, 2);
    bus.dividend = 8'd20;
    bus.divisor  = 8'd4;
    step();
    check("bb_idle_busy", 32'(bus.busy), 0);
    check("bb_idle_done", 32'(bus.done), 0);
    check("bb_idle_q", bus.quotient, 14);
    step();
    check("bb_accept2", 32'(bus.busy), 1);
    bus.start    = 1'b0;
    bus.dividend = 8'd1;
    bus.divisor  = 8'd1;
    for (int i = 1; i < int'(W); i++) step();
    check("bb_q_held", bus.quotient, 14);
    step();
    check("bb_done2", 32'(bus.done), 1);
    check("bb_q2", bus.quotient, 5);
    check("bb_r2", bus.remainder, 0);
    step();

    // Reset during the fourth CALC cycle.
    bus.start    = 1'b1;
    bus.dividend = 8'd100;
    bus.divisor  = 8'd7;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    check("mid_busy_pre", 32'(bus.busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_done", 32'(bus.done), 0);
    check("mid_q", bus.quotient, 0);
    check("mid_r", bus.remainder, 0);
    run_op("post_rst_50_6", 50, 6);

    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(255, 0));
      case ($urandom_range(3, 0))
        0:       b = 0;
        1:       b = int'($urandom_range(15, 1));
        default: b = int'($urandom_range(255, 0));
      endcase
      model(a, b, q, r);
      if (b != 0) check("rand_model_rem_lt_div", 32'(r < b), 1);
      run_op("rand", a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
